// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD up/down counter that wraps over MIN_VALUE..MAX_VALUE, with preset and 7-segment decode.
// Define BCD_WRAP_BLANK_EN to blank the tens display while the tens digit is zero.
module bcd_wrap_counter #(
    parameter int MAX_VALUE      = 23,
    parameter int MIN_VALUE      = 0,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic       dir,
    input  logic       load,
    input  logic [3:0] load_tens,
    input  logic [3:0] load_units,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [6:0] seg_tens,
    output logic [6:0] seg_units,
    output logic       carry,
    output logic       borrow,
    output logic       load_err
);

    localparam logic [3:0] MIN_TENS  = 4'(MIN_VALUE / 10);
    localparam logic [3:0] MIN_UNITS = 4'(MIN_VALUE % 10);
    localparam logic [3:0] MAX_TENS  = 4'(MAX_VALUE / 10);
    localparam logic [3:0] MAX_UNITS = 4'(MAX_VALUE % 10);
    localparam logic [7:0] MIN_V     = 8'(MIN_VALUE);
    localparam logic [7:0] MAX_V     = 8'(MAX_VALUE);
    localparam logic [6:0] SEG_BLANK = (SEG_ACTIVE_LOW != 0) ? 7'b1111111 : 7'b0000000;

    logic [7:0] value;
    logic [7:0] load_value;
    logic [8:0] below_min_diff;
    logic [8:0] above_max_diff;
    logic       load_ok;

    assign value      = ({4'd0, tens} * 8'd10) + {4'd0, units};
    assign load_value = ({4'd0, load_tens} * 8'd10) + {4'd0, load_units};

    // Range test via borrow bit of a 9-bit subtraction so a MIN_VALUE of 0 does not become a constant compare.
    assign below_min_diff = {1'b0, load_value} - {1'b0, MIN_V};
    assign above_max_diff = {1'b0, MAX_V} - {1'b0, load_value};
    assign load_ok = (load_tens <= 4'd9) && (load_units <= 4'd9)
                     && !below_min_diff[8] && !above_max_diff[8];

    always_ff @(posedge clk) begin
        if (rst) begin
            tens     <= MIN_TENS;
            units    <= MIN_UNITS;
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
        end else begin
            carry    <= 1'b0;
            borrow   <= 1'b0;
            load_err <= 1'b0;
            if (load) begin
                if (load_ok) begin
                    tens  <= load_tens;
                    units <= load_units;
                end else begin
                    tens     <= MIN_TENS;
                    units    <= MIN_UNITS;
                    load_err <= 1'b1;
                end
            end else if (inc) begin
                if (!dir) begin
                    if (value == MAX_V) begin
                        tens  <= MIN_TENS;
                        units <= MIN_UNITS;
                        carry <= 1'b1;
                    end else if (units == 4'd9) begin
                        units <= 4'd0;
                        tens  <= tens + 4'd1;
                    end else begin
                        units <= units + 4'd1;
                    end
                end else begin
                    if (value == MIN_V) begin
                        tens   <= MAX_TENS;
                        units  <= MAX_UNITS;
                        borrow <= 1'b1;
                    end else if (units == 4'd0) begin
                        units <= 4'd9;
                        tens  <= tens - 4'd1;
                    end else begin
                        units <= units - 4'd1;
                    end
                end
            end
        end
    end

    // Patterns are in active-low form ({g,f,e,d,c,b,a}, 0 = lit); polarity is applied afterwards.
    function automatic logic [6:0] seg_decode(input logic [3:0] d);
        logic [6:0] pat;
        case (d)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'b1111111;
        endcase
        return (SEG_ACTIVE_LOW != 0) ? pat : ~pat;
    endfunction

    assign seg_units = seg_decode(units);

`ifdef BCD_WRAP_BLANK_EN
    assign seg_tens = (tens == 4'd0) ? SEG_BLANK : seg_decode(tens);
`else
    assign seg_tens = seg_decode(tens);
    logic unused_blank;
    assign unused_blank = ^SEG_BLANK;
`endif

endmodule

// File: tb/tb_bcd_wrap_counter.sv
// Bench for bcd_wrap_counter: three instances (24h hours, min/sec active-high, 12h hours) share
// one stimulus stream and are compared each cycle against an integer-valued reference model.
module tb_bcd_wrap_counter;

    logic       clk = 1'b0;
    logic       rst, inc, dir, load;
    logic [3:0] loadTens, loadUnits;

    logic [3:0] tensA, unitsA, tensB, unitsB, tensC, unitsC;
    logic [6:0] segTensA, segUnitsA, segTensB, segUnitsB, segTensC, segUnitsC;
    logic       carryA, borrowA, errA, carryB, borrowB, errB, carryC, borrowC, errC;

    int assertCount = 0;
    int failCount   = 0;

    // Per-instance configuration and model state: 0 = hours 0..23, 1 = 0..59 active-high, 2 = 1..12.
    int maxV[3]    = '{23, 59, 12};
    int minV[3]    = '{0, 0, 1};
    int actLow[3]  = '{1, 0, 1};
    int modelV[3];
    bit expCarry[3], expBorrow[3], expErr[3];

    logic [6:0] segTable [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                  7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    always #5 clk = ~clk;

    bcd_wrap_counter #(.MAX_VALUE(23), .MIN_VALUE(0), .SEG_ACTIVE_LOW(1)) dutA (
        .clk(clk), .rst(rst), .inc(inc), .dir(dir), .load(load),
        .load_tens(loadTens), .load_units(loadUnits),
        .tens(tensA), .units(unitsA), .seg_tens(segTensA), .seg_units(segUnitsA),
        .carry(carryA), .borrow(borrowA), .load_err(errA));

    bcd_wrap_counter #(.MAX_VALUE(59), .MIN_VALUE(0), .SEG_ACTIVE_LOW(0)) dutB (
        .clk(clk), .rst(rst), .inc(inc), .dir(dir), .load(load),
        .load_tens(loadTens), .load_units(loadUnits),
        .tens(tensB), .units(unitsB), .seg_tens(segTensB), .seg_units(segUnitsB),
        .carry(carryB), .borrow(borrowB), .load_err(errB));

    bcd_wrap_counter #(.MAX_VALUE(12), .MIN_VALUE(1), .SEG_ACTIVE_LOW(1)) dutC (
        .clk(clk), .rst(rst), .inc(inc), .dir(dir), .load(load),
        .load_tens(loadTens), .load_units(loadUnits),
        .tens(tensC), .units(unitsC), .seg_tens(segTensC), .seg_units(segUnitsC),
        .carry(carryC), .borrow(borrowC), .load_err(errC));

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    function automatic logic [6:0] expectSeg(input int digit, input int low, input bit blank);
        logic [6:0] pat;
        pat = blank ? 7'b1111111 : segTable[digit];
        return (low != 0) ? pat : ~pat;
    endfunction

    // Reference behaviour: plain integer count with wrap, digits derived by / and %.
    task automatic modelStep(input int k);
        int lv;
        expCarry[k]  = 0;
        expBorrow[k] = 0;
        expErr[k]    = 0;
        lv = int'(loadTens) * 10 + int'(loadUnits);
        if (rst) begin
            modelV[k] = minV[k];
        end else if (load) begin
            if (loadTens <= 9 && loadUnits <= 9 && lv >= minV[k] && lv <= maxV[k]) begin
                modelV[k] = lv;
            end else begin
                modelV[k] = minV[k];
                expErr[k] = 1;
            end
        end else if (inc) begin
            if (!dir) begin
                if (modelV[k] == maxV[k]) begin
                    modelV[k] = minV[k];
                    expCarry[k] = 1;
                end else begin
                    modelV[k] = modelV[k] + 1;
                end
            end else begin
                if (modelV[k] == minV[k]) begin
                    modelV[k] = maxV[k];
                    expBorrow[k] = 1;
                end else begin
                    modelV[k] = modelV[k] - 1;
                end
            end
        end
    endtask

    task automatic checkInstance(input string name, input int k,
                                 input logic [3:0] t, input logic [3:0] u,
                                 input logic [6:0] st, input logic [6:0] su,
                                 input logic c, input logic b, input logic e);
        int  et, eu;
        bit  blankTens;
        et = modelV[k] / 10;
        eu = modelV[k] % 10;
`ifdef BCD_WRAP_BLANK_EN
        blankTens = (et == 0);
`else
        blankTens = 1'b0;
`endif
        checkOutput({name, ".tens"},     32'(t),  32'(et));
        checkOutput({name, ".units"},    32'(u),  32'(eu));
        checkOutput({name, ".seg_tens"}, 32'(st), 32'(expectSeg(et, actLow[k], blankTens)));
        checkOutput({name, ".seg_units"},32'(su), 32'(expectSeg(eu, actLow[k], 1'b0)));
        checkOutput({name, ".carry"},    32'(c),  32'(expCarry[k]));
        checkOutput({name, ".borrow"},   32'(b),  32'(expBorrow[k]));
        checkOutput({name, ".load_err"}, 32'(e),  32'(expErr[k]));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check just after it.
    task automatic applyStimulus(input logic r, input logic l, input logic [3:0] lt,
                                 input logic [3:0] lu, input logic i, input logic d);
        rst = r; load = l; loadTens = lt; loadUnits = lu; inc = i; dir = d;
        @(posedge clk);
        for (int k = 0; k < 3; k++) modelStep(k);
        #1;
        checkInstance("h24", 0, tensA, unitsA, segTensA, segUnitsA, carryA, borrowA, errA);
        checkInstance("m60", 1, tensB, unitsB, segTensB, segUnitsB, carryB, borrowB, errB);
        checkInstance("h12", 2, tensC, unitsC, segTensC, segUnitsC, carryC, borrowC, errC);
    endtask

    initial begin
        rst = 1'b0; inc = 1'b0; dir = 1'b0; load = 1'b0; loadTens = 4'd0; loadUnits = 4'd0;
        for (int k = 0; k < 3; k++) modelV[k] = minV[k];
        @(negedge clk);

        applyStimulus(1, 0, 0, 0, 0, 0);
        for (int n = 0; n < 24; n++) applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0);

        applyStimulus(0, 1, 0, 9, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);

        applyStimulus(1, 0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 1, 1);
        applyStimulus(0, 0, 0, 0, 1, 0);

        applyStimulus(0, 1, 1, 7, 1, 0);
        applyStimulus(0, 1, 2, 5, 0, 0);
        applyStimulus(0, 1, 0, 4'hA, 0, 0);
        applyStimulus(0, 1, 1, 5, 0, 0);
        applyStimulus(1, 1, 1, 5, 1, 0);
        applyStimulus(0, 1, 0, 7, 0, 0);
        applyStimulus(0, 1, 0, 0, 1, 1);

        for (int n = 0; n < 800; n++) begin
            logic r, l, i, d;
            logic [3:0] lt, lu;
            r  = ($urandom_range(0, 63) == 0);
            l  = ($urandom_range(0, 7) == 0);
            i  = ($urandom_range(0, 3) != 0);
            d  = ($urandom_range(0, 99) < ((n / 200) % 2 == 0 ? 25 : 75));
            lt = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 6));
            lu = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 9));
            applyStimulus(r, l, lt, lu, i, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/bcd_wrap_counter.md
Name: bcd_wrap_counter

Overview:
- Parametrised two-digit BCD modular counter with seven-segment decode, for the full-clock display chain (seconds, minutes and 24h/12h hours).
- Successor to the single-digit hour-units counter. The wrap point is a single generalised range MIN_VALUE..MAX_VALUE across both digits, with up/down counting, synchronous preset and a one-cycle carry/borrow pulse for cascading.
- Instances are chained: the carry or borrow of one stage drives the inc of the next.

Parameters:
- MAX_VALUE, 23, highest count value, decimal 1..99 (23 = 24h hours, 59 = min/sec, 12 = 12h hours).
- MIN_VALUE, 0, lowest count value and reset value, decimal 0..MAX_VALUE-1 (1 for 12h hours).
- SEG_ACTIVE_LOW, 1, 1 = segment bit 0 means lit (board common-anode), 0 = active-high.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous active-high reset.
- inc  in  1  count-enable strobe, one step per cycle while high.
- dir  in  1  0 = count up, 1 = count down; sampled with inc.
- load  in  1  synchronous preset strobe.
- load_tens  in  4  BCD tens value for preset.
- load_units  in  4  BCD units value for preset.
- tens  out  4  registered BCD tens digit.
- units  out  4  registered BCD units digit.
- seg_tens  out  7  segment pattern for tens, bit order {g,f,e,d,c,b,a}.
- seg_units  out  7  segment pattern for units, same order.
- carry  out  1  one-cycle pulse on up-wrap MAX_VALUE->MIN_VALUE.
- borrow  out  1  one-cycle pulse on down-wrap MIN_VALUE->MAX_VALUE.
- load_err  out  1  one-cycle pulse when a preset is rejected.

Behaviour:
- Reset (rst=1 at a clk edge): tens/units = BCD of MIN_VALUE, carry=0, borrow=0, load_err=0. rst overrides load and inc in the same cycle.
- Priority each cycle: rst > load > inc. No action when all are low. carry, borrow and load_err are cleared every cycle they are not asserted, so they are strictly single-cycle pulses.
- Up step (inc=1, dir=0):
  - If value == MAX_VALUE: go to MIN_VALUE and carry=1.
  - Else if units == 9: units=0, tens+1.
  - Else units+1.
- Down step (inc=1, dir=1):
  - If value == MIN_VALUE: go to MAX_VALUE and borrow=1.
  - Else if units == 0: units=9, tens-1.
  - Else units-1.
- Latency: the new digits are visible one cycle after the strobe. carry/borrow are asserted in the same cycle as the wrapped digits.
- Preset (load=1):
  - Accepted when both nibbles are <= 9 and MIN_VALUE <= 10*load_tens+load_units <= MAX_VALUE. Digits take the load value; no carry or borrow is generated.
  - Otherwise digits go to MIN_VALUE and load_err=1.
  - load together with inc: load wins and inc is ignored that cycle.
- Segment decode is combinational from the registered digits, so it is valid in the same cycle as tens/units.
  - Active-low patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - SEG_ACTIVE_LOW=0 inverts all seven bits.
  - Illegal digit values are unreachable; the decode default is blank (all segments off).
- Digit values are never outside 0..9, and the count never leaves MIN_VALUE..MAX_VALUE.
- Invalid parameter combinations (MIN_VALUE >= MAX_VALUE, MAX_VALUE > 99) are not supported.

Optional Feature:
- Macro: BCD_WRAP_BLANK_EN.
- Defined: seg_tens is driven to all segments off whenever tens == 0 (leading-zero blanking, e.g. hour "7" instead of "07"). tens itself is unchanged.
- Undefined: seg_tens always shows the tens digit, including 0.

Test Plan:
- Reset, MAX_VALUE=23, MIN_VALUE=0: apply 23 inc pulses -> reads 2,3, no carry. 24th inc -> 0,0 with carry=1 for exactly one cycle. seg_units=1000000 after the wrap.
- MAX_VALUE=59, value 0,9, one up inc -> tens=1, units=0, carry=0. Then dir=1 and one inc -> 0,9.
- MAX_VALUE=12, MIN_VALUE=1: reset gives 0,1. One down inc -> 1,2 with borrow=1. One up inc -> 0,1 with carry=1.
- Preset checks, MAX_VALUE=23:
  - load 1,7 together with inc=1 -> 1,7, no step.
  - load 2,5 -> 0,0 with load_err=1.
  - load units=A -> load_err=1.
- rst=1 and load=1 and inc=1 in the same cycle while at 1,5 -> 0,0, no pulses asserted.
- BCD_WRAP_BLANK_EN defined, value 0,7 -> seg_tens=1111111, seg_units=1111000. Macro undefined -> seg_tens=1000000.
